// File: rtl/round_key_store.sv
// Round-key buffer between the byte-serial AES key expansion and the round datapath.
// Packs streamed bytes into KEY_WIDTH-bit keys, stores NUM_ROUNDS+1 of them, serves one-cycle reads.
module round_key_store #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_WIDTH  = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           key_byte,
    input  logic                 key_valid,
    input  logic                 rd_req,
    input  logic [3:0]           rd_round,
    output logic [KEY_WIDTH-1:0] rd_key,
    output logic                 rd_valid,
    output logic                 rd_miss,
    output logic [3:0]           wr_round,
    output logic                 all_ready,
    output logic                 overflow_err
);

    localparam int BYTES   = KEY_WIDTH / 8;
    localparam int CNT_W   = $clog2(BYTES);
    localparam int ENTRIES = NUM_ROUNDS + 1;
    localparam logic [CNT_W-1:0] LAST_BYTE  = CNT_W'(BYTES - 1);
    localparam logic [3:0]       LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    state_t               state, state_next;
    logic                 capture, drop_byte, key_done, rd_hit;
    logic [CNT_W-1:0]     byte_cnt;
    logic [KEY_WIDTH-9:0] asm_reg;
    logic [ENTRIES-1:0]   valid;
    logic [KEY_WIDTH-1:0] entry [ENTRIES];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: each combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        if (start)
            state_next = COLLECT;
        else if (key_done && wr_round == LAST_ROUND)
            state_next = FULL;
    end

    always_comb begin
        capture   = (state == COLLECT) && key_valid && !start;
        drop_byte = (state == FULL) && key_valid && !start;
        key_done  = capture && (byte_cnt == LAST_BYTE);
        all_ready = (state == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt     <= '0;
            asm_reg      <= '0;
            wr_round     <= '0;
            valid        <= '0;
            overflow_err <= 1'b0;
        end else if (start) begin
            byte_cnt     <= '0;
            wr_round     <= '0;
            valid        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (capture) begin
                asm_reg  <= {asm_reg[KEY_WIDTH-17:0], key_byte};
                byte_cnt <= key_done ? '0 : byte_cnt + 1'b1;
            end
            // wr_round parks on the last entry once the schedule is complete
            if (key_done) begin
                valid[wr_round] <= 1'b1;
                if (wr_round != LAST_ROUND)
                    wr_round <= wr_round + 1'b1;
            end
            if (drop_byte)
                overflow_err <= 1'b1;
        end
    end

    // NOTE: the key storage has no reset; the valid mask alone decides what may be read.
    always_ff @(posedge clk) begin
        if (key_done)
            entry[wr_round] <= {asm_reg, key_byte};
    end

    assign rd_hit = (rd_round <= LAST_ROUND) && valid[rd_round];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
            rd_miss  <= 1'b0;
        end else if (!rd_req) begin
            rd_valid <= 1'b0;
            rd_miss  <= 1'b0;
        end else if (rd_hit) begin
            rd_key   <= entry[rd_round];
            rd_valid <= 1'b1;
            rd_miss  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_miss  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_round_key_store.sv
// Randomized bench for round_key_store against a byte-list reference model of the key store.
module tb_round_key_store;

    logic         clk = 1'b0;
    logic         rst, start, key_valid, rd_req;
    logic [7:0]   key_byte;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         rd_valid, rd_miss, all_ready, overflow_err;
    logic [3:0]   wr_round;

    round_key_store #(.NUM_ROUNDS(10), .KEY_WIDTH(128)) dut (
        .clk(clk), .rst(rst), .start(start), .key_byte(key_byte), .key_valid(key_valid),
        .rd_req(rd_req), .rd_round(rd_round), .rd_key(rd_key), .rd_valid(rd_valid),
        .rd_miss(rd_miss), .wr_round(wr_round), .all_ready(all_ready), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // FIPS-197 A.1 expanded schedule for key 2b7e1516...
    logic [127:0] fips_rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the list of bytes accepted since the last start defines everything.
    logic [127:0] m_mem [16];
    logic [7:0]   m_bytes [$];
    bit           m_active, m_full, m_ovf;
    logic [127:0] exp_key;
    bit           exp_rv, exp_miss;

    function automatic bit m_valid(input int k);
        return (k <= 10) && (m_bytes.size() >= 16 * (k + 1));
    endfunction

    function automatic int m_wr_round();
        int n = m_bytes.size() / 16;
        return (n > 10) ? 10 : n;
    endfunction

    task automatic model_reset();
        m_bytes.delete();
        m_active = 0;
        m_full   = 0;
        m_ovf    = 0;
        exp_key  = '0;
        exp_rv   = 0;
        exp_miss = 0;
    endtask

    task automatic check_outputs(input string when);
        check({when, " rd_valid"}, rd_valid, exp_rv);
        check({when, " rd_miss"}, rd_miss, exp_miss);
        check({when, " rd_key"}, rd_key, exp_key);
        check({when, " wr_round"}, wr_round, m_wr_round());
        check({when, " all_ready"}, all_ready, m_full);
        check({when, " overflow_err"}, overflow_err, m_ovf);
    endtask

    task automatic cycle(input bit s, input bit kv, input logic [7:0] kb, input bit rr, input logic [3:0] rrd);
        int           k;
        logic [127:0] v;
        start = s; key_valid = kv; key_byte = kb; rd_req = rr; rd_round = rrd;
        if (rr) begin
            if (m_valid(int'(rrd))) begin
                exp_key = m_mem[rrd]; exp_rv = 1; exp_miss = 0;
            end else begin
                exp_rv = 0; exp_miss = 1;
            end
        end else begin
            exp_rv = 0; exp_miss = 0;
        end
        if (s) begin
            m_active = 1; m_full = 0; m_ovf = 0;
            m_bytes.delete();
        end else if (m_full && kv) begin
            m_ovf = 1;
        end else if (m_active && kv) begin
            m_bytes.push_back(kb);
            if (m_bytes.size() % 16 == 0) begin
                k = m_bytes.size() / 16 - 1;
                v = '0;
                for (int i = 0; i < 16; i++) v = {v[119:0], m_bytes[16 * k + i]};
                m_mem[k] = v;
                if (k == 10) begin m_full = 1; m_active = 0; end
            end
        end
        @(posedge clk);
        #1;
        check_outputs("cycle");
    endtask

    task automatic rand_cycle(input bit kv, input logic [7:0] kb);
        cycle(1'b0, kv, kb, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    endtask

    task automatic feed(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) rand_cycle(1'b0, 8'($urandom));
        rand_cycle(1'b1, b);
    endtask

    task automatic read_at(input logic [3:0] r);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, r);
    endtask

    task automatic do_start();
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
    endtask

    initial begin
        rst = 1'b1; start = 0; key_valid = 0; key_byte = 0; rd_req = 0; rd_round = 0;
        model_reset();
        #2;
        check_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // IDLE ignores key_valid
        repeat (5) rand_cycle(1'b1, 8'($urandom));
        check("idle wr_round", wr_round, 4'd0);

        // FIPS-197 schedule
        do_start();
        for (int k = 0; k < 11; k++)
            for (int j = 0; j < 16; j++)
                feed(fips_rk[k][127 - 8 * j -: 8]);
        check("full all_ready", all_ready, 1'b1);
        read_at(4'd0);
        check("fips round0 key", rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("fips round0 valid", rd_valid, 1'b1);
        read_at(4'd10);
        check("fips round10 key", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("fips round10 valid", rd_valid, 1'b1);

        // Out of range reads miss and leave rd_key alone
        read_at(4'd11);
        check("oor11 miss", rd_miss, 1'b1);
        check("oor11 key held", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_at(4'd15);
        check("oor15 miss", rd_miss, 1'b1);
        check("oor15 valid", rd_valid, 1'b0);

        // Overflow in FULL
        cycle(1'b0, 1'b1, 8'h55, 1'b0, 4'd0);
        check("overflow set", overflow_err, 1'b1);
        read_at(4'd10);
        check("overflow round10 key", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // start mid-collection, coinciding with a valid byte
        do_start();
        check("restart overflow clear", overflow_err, 1'b0);
        check("restart all_ready", all_ready, 1'b0);
        for (int i = 0; i < 20; i++) feed(8'($urandom));
        cycle(1'b1, 1'b1, 8'haa, 1'b0, 4'd0);
        check("start wins wr_round", wr_round, 4'd0);
        read_at(4'd0);
        check("restart round0 miss", rd_miss, 1'b1);
        for (int i = 0; i < 15; i++) feed(8'($urandom));
        read_at(4'd0);
        check("15 bytes round0 miss", rd_miss, 1'b1);
        feed(8'($urandom));
        read_at(4'd0);
        check("16 bytes round0 hit", rd_valid, 1'b1);

        // Partial schedule of 40 bytes
        do_start();
        for (int i = 0; i < 40; i++) feed(8'($urandom));
        read_at(4'd0);
        check("partial round0 hit", rd_valid, 1'b1);
        read_at(4'd1);
        check("partial round1 hit", rd_valid, 1'b1);
        read_at(4'd2);
        check("partial round2 miss", rd_miss, 1'b1);
        check("partial wr_round", wr_round, 4'd2);
        check("partial all_ready", all_ready, 1'b0);

        // Random full load and read soak
        do_start();
        for (int i = 0; i < 176; i++) feed(8'($urandom));
        repeat (60) rand_cycle(1'($urandom_range(0, 1)), 8'($urandom));

        // Asynchronous reset between edges during collection
        do_start();
        for (int i = 0; i < 10; i++) feed(8'($urandom));
        read_at(4'd11);
        #3 rst = 1'b1;
        model_reset();
        #1;
        check_outputs("async reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) rand_cycle(1'b1, 8'($urandom));
        check("post reset idle wr_round", wr_round, 4'd0);
        read_at(4'd0);
        check("post reset round0 miss", rd_miss, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/round_key_store.md
# round_key_store

Buffers the AES-128 key schedule between the byte-serial key expansion controller and the round datapath. Accepts the expanded round-key bytes as they stream out, assembles each group of 16 bytes into a 128-bit round key, and holds all 11 keys in a small register file. Provides a one-cycle random-access read port, so the encryption or decryption datapath can fetch any round key in any order.

## Interface
Parameters:
- NUM_ROUNDS, 10: last round index; the store holds NUM_ROUNDS+1 entries.
- KEY_WIDTH, 128: round-key width; must be a multiple of 8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  one-cycle pulse; clears the store and begins capturing a new schedule.
- key_byte  input  8  round-key byte from key expansion, most significant byte of each key first.
- key_valid  input  1  key_byte is valid this cycle.
- rd_req  input  1  read request.
- rd_round  input  4  round index to read.
- rd_key  output  KEY_WIDTH  registered read data.
- rd_valid  output  1  rd_key holds a stored key this cycle.
- rd_miss  output  1  the request targeted an unwritten or out-of-range entry.
- wr_round  output  4  index of the entry being assembled.
- all_ready  output  1  all NUM_ROUNDS+1 entries are written.
- overflow_err  output  1  sticky flag; a byte arrived while the store was FULL.

## Operation
- The FSM has three states: IDLE, COLLECT and FULL. Reset and power-up state is IDLE.
- In IDLE, key_valid is ignored.
- start in any state moves the FSM to COLLECT and clears the following: byte_cnt, wr_round, the valid mask (one bit per entry), all_ready and overflow_err. Entry contents are not cleared.
- COLLECT, on each cycle with key_valid high:
  - asm <= {asm[KEY_WIDTH-9:0], key_byte}, and byte_cnt increments.
  - When byte_cnt == KEY_WIDTH/8-1, entry[wr_round] <= {asm[KEY_WIDTH-9:0], key_byte}.
  - The same edge sets valid[wr_round], clears byte_cnt and increments wr_round.
- On the write that completes entry NUM_ROUNDS:
  - the FSM moves to FULL and all_ready goes to 1;
  - wr_round holds at NUM_ROUNDS and does not wrap.
- In FULL, key_valid sets overflow_err and the byte is dropped. Entries are unchanged.
- If start and key_valid are high in the same cycle, start wins and the byte is discarded.
- Gaps in key_valid are allowed. Partial assembly persists across idle cycles.
- Read port, evaluated on every edge:
  - If rd_req is low, rd_valid <= 0 and rd_miss <= 0; rd_key holds its last value.
  - If rd_req is high, rd_round <= NUM_ROUNDS and valid[rd_round] is set (state before the edge), then rd_key <= entry[rd_round], rd_valid <= 1 and rd_miss <= 0.
  - Any other request gives rd_valid <= 0 and rd_miss <= 1; rd_key holds.
- Read and write to the same entry on the same edge: the read sees the pre-edge state. A first-time write therefore returns rd_miss.
- Reset values: rd_key 0, rd_valid 0, rd_miss 0, wr_round 0, all_ready 0, overflow_err 0. The valid mask, asm and byte_cnt are also 0. FSM state is IDLE.
- Reset asserted mid-collection discards all progress immediately, with no clock required.

## Timing
- Write latency: entry k is readable from the edge that captures its 16th byte. A request issued in the following cycle returns it.
- all_ready rises on the edge that captures byte number 16×(NUM_ROUNDS+1), which is byte 176 by default.
- Read latency is 1 cycle from rd_req to rd_valid/rd_miss. Throughput is one read per cycle, with no back-pressure.
- rd_valid and rd_miss are never high together.
- start takes effect at the edge where it is sampled. all_ready is 0 from the next cycle.

## Test plan
- FIPS-197 key: after reset and start, stream the 176 expanded bytes of key 2b7e151628aed2a6abf7158809cf4f3c.
  - all_ready rises on byte 176.
  - rd_round=0 returns 2b7e151628aed2a6abf7158809cf4f3c.
  - rd_round=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6, each with rd_valid one cycle later.
- Partial schedule: stream 40 bytes with random key_valid gaps.
  - Reads of rounds 0 and 1 hit.
  - Round 2 returns rd_miss=1.
  - wr_round is 2 and all_ready is 0.
- Out of range: after a full load, rd_round=11 and rd_round=15 give rd_miss=1, and rd_key is unchanged.
- Overflow: after FULL, one extra key_valid byte sets overflow_err=1. Round 10 still reads d014f9a8….
- start mid-collection: pulse start after byte 20 together with key_valid high.
  - That byte is dropped and wr_round returns to 0.
  - Round 0 misses until 16 new bytes arrive.
  - overflow_err clears.
- Asynchronous reset: assert rst between clock edges during COLLECT. All outputs go to their reset values before the next edge, and the FSM is IDLE.
